// File: rtl/pipe_pkg.sv
// Shared types for the two-entry pipeline stage register.
// The occupancy state encoding equals the live entry count.
package pipe_pkg;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        HALF  = 2'd1,
        FULL  = 2'd2
    } occ_state_e;

    function automatic logic [1:0] occ_count(input occ_state_e s);
        return s;
    endfunction

endpackage

// File: rtl/pipe_stage_reg_if.sv
// Valid/ready handshake bundle for pipe_stage_reg: upstream, downstream, flush and occupancy.
interface pipe_stage_reg_if #(
    parameter int WIDTH = 151
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;
    logic             flush;
    logic [1:0]       occupancy;

    modport master (
        output in_valid, in_data, out_ready, flush,
        input  in_ready, out_valid, out_data, occupancy
    );

    modport slave (
        input  in_valid, in_data, out_ready, flush,
        output in_ready, out_valid, out_data, occupancy
    );
endinterface

// File: rtl/pipe_data_reg.sv
// WIDTH-bit data register with synchronous load of RESET_VAL and a write enable.
module pipe_data_reg #(
    parameter int               WIDTH     = 151,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             we,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            q <= RESET_VAL;
        end else if (we) begin
            q <= d;
        end
    end

endmodule

// File: rtl/pipe_stage_reg.sv
// Two-entry skid-buffered pipeline stage: main entry drives out_data, skid absorbs one beat of backpressure.
module pipe_stage_reg
    import pipe_pkg::*;
#(
    parameter int               WIDTH          = 151,
    parameter logic [WIDTH-1:0] RESET_VAL      = '0,
    parameter bit               CLEAR_ON_FLUSH = 1'b0
) (
    input logic             clk,
    input logic             reset,
    pipe_stage_reg_if.slave bus
);

    occ_state_e       state;
    occ_state_e       next_state;
    logic             in_ready_q;
    logic             out_valid_q;
    logic             in_fire;
    logic             out_fire;
    logic             main_we;
    logic             skid_we;
    logic             data_clear;
    logic [WIDTH-1:0] main_d;
    logic [WIDTH-1:0] main_q;
    logic [WIDTH-1:0] skid_q;

    assign in_fire    = bus.in_valid & in_ready_q;
    assign out_fire   = out_valid_q & bus.out_ready;
    assign data_clear = reset | (CLEAR_ON_FLUSH & bus.flush);

    // NOTE: every always_comb output gets a default first, so no path leaves it unassigned (no latch).
    always_comb begin
        next_state = state;
        main_we    = 1'b0;
        skid_we    = 1'b0;
        main_d     = bus.in_data;
        unique case (state)
            EMPTY: begin
                if (in_fire) begin
                    main_we    = 1'b1;
                    next_state = HALF;
                end
            end
            HALF: begin
                if (in_fire && out_fire) begin
                    main_we = 1'b1;
                end else if (in_fire) begin
                    skid_we    = 1'b1;
                    next_state = FULL;
                end else if (out_fire) begin
                    next_state = EMPTY;
                end
            end
            FULL: begin
                if (out_fire) begin
                    main_we    = 1'b1;
                    main_d     = skid_q;
                    next_state = HALF;
                end
            end
            default: next_state = EMPTY;
        endcase
        // A killed stage discards everything, including a beat accepted this cycle.
        if (bus.flush) begin
            next_state = EMPTY;
            main_we    = 1'b0;
            skid_we    = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= EMPTY;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            state       <= next_state;
            in_ready_q  <= (next_state != FULL);
            out_valid_q <= (next_state != EMPTY);
        end
    end

    pipe_data_reg #(
        .WIDTH     (WIDTH),
        .RESET_VAL (RESET_VAL)
    ) u_main (
        .clk   (clk),
        .reset (data_clear),
        .we    (main_we),
        .d     (main_d),
        .q     (main_q)
    );

    pipe_data_reg #(
        .WIDTH     (WIDTH),
        .RESET_VAL (RESET_VAL)
    ) u_skid (
        .clk   (clk),
        .reset (data_clear),
        .we    (skid_we),
        .d     (bus.in_data),
        .q     (skid_q)
    );

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = main_q;
    assign bus.occupancy = occ_count(state);

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Scoreboard bench for pipe_stage_reg: directed scenarios followed by randomized valid/ready/flush/reset traffic.
module tb_pipe_stage_reg;

    localparam int           W  = 151;
    localparam logic [W-1:0] RV = '0;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    pipe_stage_reg_if #(.WIDTH(W)) bus ();

    pipe_stage_reg #(
        .WIDTH          (W),
        .RESET_VAL      (RV),
        .CLEAR_ON_FLUSH (1'b0)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int checks = 0;
    int passed = 0;

    // Reference model: the stage is a FIFO of capacity two; its contents are the scoreboard.
    logic [W-1:0] sb[$];
    logic [W-1:0] last_data;
    bit           armed = 1'b0;

    task automatic check(input string name, input logic [W-1:0] got, input logic [W-1:0] exp);
        checks++;
        if (got === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", name, got, exp);
    endtask

    function automatic logic [W-1:0] rand_data();
        logic [159:0] r;
        r = {$urandom, $urandom, $urandom, $urandom, $urandom};
        return r[W-1:0];
    endfunction

    // Inputs change 1 time unit after the rising edge and hold for the whole cycle.
    task automatic drive(input bit r, input bit iv, input logic [W-1:0] d, input bit ordy, input bit fl);
        @(posedge clk);
        #1;
        reset         = r;
        bus.in_valid  = iv;
        bus.in_data   = d;
        bus.out_ready = ordy;
        bus.flush     = fl;
    endtask

    task automatic idle(input int n, input bit ordy);
        for (int i = 0; i < n; i++) drive(1'b0, 1'b0, '0, ordy, 1'b0);
    endtask

    // Monitor: at each falling edge compare the DUT against the model, then advance the model
    // by the handshakes that will complete at the coming rising edge.
    initial begin
        int n;
        bit in_f;
        bit out_f;
        forever begin
            @(negedge clk);
            if (reset) begin
                sb.delete();
                last_data = RV;
                armed     = 1'b1;
            end else if (armed) begin
                n = sb.size();
                check("occupancy", W'(bus.occupancy), W'(n));
                check("in_ready",  W'(bus.in_ready),  W'(n < 2));
                check("out_valid", W'(bus.out_valid), W'(n > 0));
                if (n > 0) begin
                    check("out_data", bus.out_data, sb[0]);
                    last_data = sb[0];
                end else begin
                    check("out_data_hold", bus.out_data, last_data);
                end
                in_f  = bus.in_valid && (n < 2);
                out_f = bus.out_ready && (n > 0);
                if (bus.flush) begin
                    sb.delete();
                end else begin
                    if (out_f) void'(sb.pop_front());
                    if (in_f) sb.push_back(bus.in_data);
                end
            end
        end
    end

    initial begin
        reset         = 1'b1;
        bus.in_valid  = 1'b1;
        bus.in_data   = W'(8'h55);
        bus.out_ready = 1'b0;
        bus.flush     = 1'b0;

        // Reset held two cycles with in_valid high: nothing may be captured.
        drive(1'b1, 1'b1, W'(8'h55), 1'b0, 1'b0);
        idle(2, 1'b1);

        // Streaming at full throughput.
        for (int i = 1; i <= 8; i++) drive(1'b0, 1'b1, W'(i), 1'b1, 1'b0);
        idle(2, 1'b1);

        // Backpressure: fill both entries, stall, then drain.
        drive(1'b0, 1'b1, W'(8'h0A), 1'b0, 1'b0);
        drive(1'b0, 1'b1, W'(8'h0B), 1'b0, 1'b0);
        drive(1'b0, 1'b1, W'(8'h0D), 1'b0, 1'b0);
        idle(2, 1'b0);
        idle(3, 1'b1);

        // Flush while full, with a simultaneous beat offered.
        drive(1'b0, 1'b1, W'(8'h0A), 1'b0, 1'b0);
        drive(1'b0, 1'b1, W'(8'h0B), 1'b0, 1'b0);
        drive(1'b0, 1'b1, W'(8'h0C), 1'b0, 1'b1);
        idle(3, 1'b1);

        // Reset while full, colliding with flush and a ready downstream.
        drive(1'b0, 1'b1, W'(8'h0A), 1'b0, 1'b0);
        drive(1'b0, 1'b1, W'(8'h0B), 1'b0, 1'b0);
        drive(1'b1, 1'b1, W'(8'h0E), 1'b1, 1'b1);
        idle(3, 1'b1);

        // Randomized traffic.
        for (int i = 0; i < 10000; i++) begin
            drive($urandom_range(0, 999) < 3,
                  $urandom_range(0, 9) < 7,
                  rand_data(),
                  $urandom_range(0, 9) < 6,
                  $urandom_range(0, 99) < 2);
        end
        idle(4, 1'b1);
        @(negedge clk);
        #1;
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
